pulp_clock_gate_ctrl: RTL and testbench
=======================================

// Module: pulp_clock_gate_ctrl
// PURPOSE
//   Auto clock-gating controller for NUM_CH gated clock domains. Drives en_i of one
//   pulp_clock_gating2 ICG per channel: gates a channel after IDLE_CYCLES idle cycles.
//   Re-enables it on request, then holds ready_o low for WAKE_CYCLES while the domain settles.
//   Wake-ups are arbitrated round-robin, at most one channel waking at a time, to limit inrush.
// PARAMETERS
//   NUM_CH       4   number of gated channels (>=1)
//   IDLE_CYCLES  16  consecutive idle samples before gating (>=1)
//   WAKE_CYCLES  4   cycles in WAKE before ready_o asserts (>=1)
//   (derived) CNT_W = $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1), per-channel counter width
// PORTS
//   clk_i      in   1       ungated source clock
//   rst_i      in   1       synchronous, active-high reset
//   enable_i   in   1       1: auto-gating allowed; 0: force all channels back on
//   req_i      in   NUM_CH  channel wants its clock (level)
//   busy_i     in   NUM_CH  channel has work in flight (level; ignored while OFF)
//   clk_en_o   out  NUM_CH  ICG enable per channel (registered)
//   ready_o    out  NUM_CH  channel clock running and settled (registered)
// BEHAVIOUR
//   - One clock, clk_i. Reset is synchronous and active-high on rst_i.
//   - Reset, including mid-operation: every channel goes to RUN; clk_en_o=all 1; ready_o=all 1.
//     Counters=0; round-robin pointer=0. Takes effect at the first rising edge with rst_i=1.
//   - "Idle" for channel i = enable_i & ~req_i[i] & ~busy_i[i], sampled at each rising edge.
//   - States per channel, with outputs (en, rdy):
//     RUN(1,1)  IDLE(1,1)  OFF(0,0)  WAKE(1,0).
//   - RUN:  idle -> IDLE with cnt=1. If IDLE_CYCLES==1, idle goes straight to OFF.
//   - IDLE: not idle -> RUN, cnt cleared.
//           idle & cnt==IDLE_CYCLES-1 -> OFF. Otherwise cnt++.
//     So clk_en_o falls right after the edge that samples the IDLE_CYCLES-th consecutive idle.
//   - OFF:  wake-pending = req_i[i] | ~enable_i.
//           Pending & granted -> WAKE with cnt=0. clk_en_o rises after that same edge.
//   - WAKE: cnt==WAKE_CYCLES-1 -> RUN, else cnt++. Not abortable.
//     A req_i/enable_i change during WAKE does not stop it. After RUN, normal idle rules apply.
//   - Wake latency, uncontended: req sampled at edge k.
//     clk_en_o=1 after edge k; ready_o=1 after edge k+WAKE_CYCLES.
//   - Arbiter, combinational from current state:
//     a grant is issued only if no channel is currently in WAKE.
//     Grant goes to the first pending OFF channel, searching from ptr upward with wrap.
//     On a grant, ptr <= granted+1 (mod NUM_CH). With no grant, ptr holds.
//   - Back-to-back wakes: the next grant happens one edge after the previous channel leaves WAKE.
//     Spacing between clk_en_o rises is therefore WAKE_CYCLES+1 cycles.
//   - enable_i=0: IDLE channels -> RUN at the next edge.
//     OFF channels become pending and wake serially in round-robin order. RUN is unaffected.
//   - busy_i while OFF is a protocol error and is ignored. Simulation-only assertion flags it.
//   - Assertions: at most one channel in WAKE; clk_en_o[i]==0 implies ready_o[i]==0.
// TESTING
//   - Reset: NUM_CH=4, IDLE=16, WAKE=4; rst_i=1 mid-WAKE on ch2
//     -> next edge clk_en_o=4'hF, ready_o=4'hF, ptr=0.
//   - Auto-gate: enable_i=1, ch0 req/busy=0 from edge 1, ch1-3 req=1
//     -> clk_en_o[0]=0 and ready_o[0]=0 after edge 16; others stay 1.
//   - Idle restart: ch0 busy=1 for one cycle at idle sample 10
//     -> no gating; clk_en_o[0] falls 16 samples after busy drops.
//   - Single wake: ch0 OFF, req_i[0]=1 sampled edge k
//     -> clk_en_o[0]=1 after k; ready_o[0]=0 until after edge k+4, then 1.
//   - Contention: all 4 OFF, req_i=4'hF same edge k, ptr=0
//     -> clk_en_o rises ch0@k, ch1@k+5, ch2@k+10, ch3@k+15.
//     All ready after k+19. Never two channels in WAKE at once.
//   - Force-on: ch1 IDLE, ch0/ch3 OFF, enable_i 1->0
//     -> ch1 RUN next edge; ch0 then ch3 wake 5 cycles apart; no new gating while enable_i=0.

Source files
------------

// File: rtl/pulp_clock_gate_ctrl.sv
// Auto clock-gating controller: per-channel RUN/IDLE/OFF/WAKE state machines
// driving ICG enables, with a round-robin arbiter that serialises wake-ups.
module pulp_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] busy_i,
  output logic [NUM_CH-1:0] clk_en_o,
  output logic [NUM_CH-1:0] ready_o
);

  localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_e;

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0]  clk_en_q, clk_en_d;
  logic [NUM_CH-1:0]  ready_q, ready_d;

  logic [NUM_CH-1:0]  idle_s, pending_s, wake_s, off_s, gnt_vec_s;
  logic               any_wake_s, gnt_vld_s;
  logic [PTR_W-1:0]   gnt_idx_s, idx_s;
  logic [PTR_W:0]     sum_s;

  // Per-channel status decode.
  always_comb begin
    idle_s    = '0;
    pending_s = '0;
    wake_s    = '0;
    off_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idle_s[i]    = enable_i & ~req_i[i] & ~busy_i[i];
      wake_s[i]    = (state_q[i] == ST_WAKE);
      off_s[i]     = (state_q[i] == ST_OFF);
      pending_s[i] = off_s[i] & (req_i[i] | ~enable_i);
    end
    any_wake_s = |wake_s;
  end

  // Round-robin wake arbiter; no grant while any channel is still settling.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    gnt_vec_s = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = {1'b0, ptr_q} + (PTR_W+1)'(k);
      idx_s = (sum_s >= (PTR_W+1)'(NUM_CH)) ? PTR_W'(sum_s - (PTR_W+1)'(NUM_CH))
                                             : PTR_W'(sum_s);
      if (!any_wake_s && !gnt_vld_s && pending_s[idx_s]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = idx_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s) begin
      gnt_vec_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_vec_s = '0;
    end
  end

  // Next-state, counters, pointer and registered-output values.
  always_comb begin
    ptr_d    = ptr_q;
    clk_en_d = '0;
    ready_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (idle_s[i]) begin
            if (IDLE_CYCLES == 1) begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = CNT_W'(1);
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_IDLE: begin
          if (!idle_s[i]) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(IDLE_CYCLES - 1)) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (gnt_vec_s[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_WAKE: begin
          if (cnt_q[i] == CNT_W'(WAKE_CYCLES - 1)) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_RUN;
          cnt_d[i]   = '0;
        end
      endcase
      clk_en_d[i] = (state_d[i] != ST_OFF);
      ready_d[i]  = (state_d[i] == ST_RUN) || (state_d[i] == ST_IDLE);
    end
    if (gnt_vld_s) begin
      ptr_d = (gnt_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      ptr_q    <= '0;
      clk_en_q <= '1;
      ready_q  <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q    <= ptr_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign ready_o  = ready_q;

  pulp_clock_gate_ctrl_chk #(
    .NUM_CH (NUM_CH)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wake_i   (wake_s),
    .off_i    (off_s),
    .busy_i   (busy_i),
    .clk_en_i (clk_en_q),
    .ready_i  (ready_q)
  );

endmodule

// Protocol and invariant checks for the gate controller.
module pulp_clock_gate_ctrl_chk #(
  parameter int NUM_CH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NUM_CH-1:0] wake_i,
  input logic [NUM_CH-1:0] off_i,
  input logic [NUM_CH-1:0] busy_i,
  input logic [NUM_CH-1:0] clk_en_i,
  input logic [NUM_CH-1:0] ready_i
);

  a_one_wake: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(wake_i));
  a_rdy_needs_en: assert property (@(posedge clk_i) disable iff (rst_i)
                                   ((~clk_en_i & ready_i) == '0));
  a_no_busy_off: assert property (@(posedge clk_i) disable iff (rst_i)
                                  ((off_i & busy_i) == '0));

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Scoreboard bench for pulp_clock_gate_ctrl: stimulus queues hand-computed
// {clk_en_o, ready_o} per cycle, a monitor compares after each rising edge.
module tb_pulp_clock_gate_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b1;
  logic [3:0] req_i = 4'hF;
  logic [3:0] busy_i = 4'h0;
  logic [3:0] clk_en_o;
  logic [3:0] ready_o;

  logic [7:0] exp_q [$];
  string      name_q [$];
  int         n_vec = 0;
  int         n_bad = 0;

  pulp_clock_gate_ctrl #(
    .NUM_CH      (4),
    .IDLE_CYCLES (16),
    .WAKE_CYCLES (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .req_i    (req_i),
    .busy_i   (busy_i),
    .clk_en_o (clk_en_o),
    .ready_o  (ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic rst, input logic en, input logic [3:0] req,
                     input logic [3:0] busy, input logic [3:0] xen,
                     input logic [3:0] xrdy, input string nm);
    @(negedge clk_i);
    rst_i    = rst;
    enable_i = en;
    req_i    = req;
    busy_i   = busy;
    exp_q.push_back({xen, xrdy});
    name_q.push_back(nm);
  endtask

  // Monitor: compare DUT outputs just after every rising edge.
  initial begin
    logic [7:0] e;
    string      nm;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if ({clk_en_o, ready_o} !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: clk_en_o=%h ready_o=%h, expected clk_en_o=%h ready_o=%h",
                   nm, $time, clk_en_o, ready_o, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] xe, xr;

    // Reset state.
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF, "reset");
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF, "reset");

    // Auto-gate ch0 after 16 idle samples.
    for (int i = 1; i <= 20; i++) begin
      xe = (i >= 16) ? 4'hE : 4'hF;
      cyc(1'b0, 1'b1, 4'hE, 4'h0, xe, xe, "autogate");
    end

    // Single uncontended wake of ch0.
    for (int j = 0; j <= 4; j++) begin
      xr = (j < 4) ? 4'hE : 4'hF;
      cyc(1'b0, 1'b1, 4'hF, 4'h0, 4'hF, xr, "single_wake");
    end

    // Idle restart: busy pulse at idle sample 10.
    for (int i = 1; i <= 27; i++) begin
      xe = (i >= 26) ? 4'hE : 4'hF;
      cyc(1'b0, 1'b1, 4'hE, (i == 10) ? 4'h1 : 4'h0, xe, xe, "idle_restart");
    end

    // Reset again, then gate all four channels.
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF, "reset2");
    for (int i = 1; i <= 17; i++) begin
      xe = (i >= 16) ? 4'h0 : 4'hF;
      cyc(1'b0, 1'b1, 4'h0, 4'h0, xe, xe, "gate_all");
    end

    // Contention: all request on the same edge, served 5 cycles apart.
    for (int j = 0; j <= 21; j++) begin
      for (int c = 0; c < 4; c++) begin
        xe[c] = (j >= 5 * c);
        xr[c] = (j >= 5 * c + 4);
      end
      cyc(1'b0, 1'b1, 4'hF, 4'h0, xe, xr, "contention");
    end

    // Force-on setup: gate ch0/ch3, put ch1 in IDLE.
    for (int i = 1; i <= 16; i++) begin
      xe = (i >= 16) ? 4'h6 : 4'hF;
      cyc(1'b0, 1'b1, 4'h6, 4'h0, xe, xe, "forceon_setup");
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 4'h4, 4'h0, 4'h6, 4'h6, "forceon_idle");
    end
    // enable_i low: ch0 then ch3 wake 5 cycles apart.
    for (int j = 0; j <= 12; j++) begin
      xe = {(j >= 5) ? 1'b1 : 1'b0, 2'b11, 1'b1};
      xr = {(j >= 9) ? 1'b1 : 1'b0, 2'b11, (j >= 4) ? 1'b1 : 1'b0};
      cyc(1'b0, 1'b0, 4'h4, 4'h0, xe, xr, "forceon_wake");
    end
    // No gating while enable_i is low.
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, "forceon_hold");
    end
    // Re-enable: everything is in RUN, so all gate after 16 idle samples.
    for (int i = 1; i <= 16; i++) begin
      xe = (i >= 16) ? 4'h0 : 4'hF;
      cyc(1'b0, 1'b1, 4'h0, 4'h0, xe, xe, "reenable_gate");
    end

    // Reset in the middle of a ch2 wake.
    for (int j = 0; j <= 1; j++) begin
      cyc(1'b0, 1'b1, 4'h4, 4'h0, 4'h4, 4'h0, "wake_ch2");
    end
    cyc(1'b1, 1'b1, 4'h4, 4'h0, 4'hF, 4'hF, "reset_mid_wake");
    cyc(1'b0, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF, "after_reset");

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 5 && exp_q.size() != 0; w++) begin
      @(posedge clk_i);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
